// File: rtl/sweep_ctrl_if.sv
// sweep_ctrl_if: handshake, stimulus and result signals of the truth-table sweeper
interface sweep_ctrl_if;
  logic        start;
  logic        abort;
  logic        f_in;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic [3:0]  vec_idx;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] truth;
  logic [4:0]  zero_cnt;
  modport master (
    output start, abort, f_in,
    input  a, b, c, d, vec_idx, busy, done, aborted, truth, zero_cnt
  );
  modport slave (
    input  start, abort, f_in,
    output a, b, c, d, vec_idx, busy, done, aborted, truth, zero_cnt
  );
endinterface

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: drives all 16 vectors of a 4-input function for DWELL cycles each and captures its truth table
module sweep_ctrl #(
  parameter int DWELL = 4
) (
  input logic         clk,
  input logic         rst,
  sweep_ctrl_if.slave s
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t     state;
  logic [3:0] dwell_cnt;
  logic [3:0] abcd;
  logic       sample;
  assign sample = dwell_cnt == 4'(DWELL - 1);
  assign {s.a, s.b, s.c, s.d} = abcd;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      dwell_cnt  <= '0;
      abcd       <= '0;
      s.vec_idx  <= '0;
      s.busy     <= 1'b0;
      s.done     <= 1'b0;
      s.aborted  <= 1'b0;
      s.truth    <= '0;
      s.zero_cnt <= '0;
    end else begin
      s.done <= 1'b0;
      case (state)
        IDLE:
          if (s.start) begin
            state      <= RUN;
            dwell_cnt  <= '0;
            abcd       <= '0;
            s.vec_idx  <= '0;
            s.busy     <= 1'b1;
            s.aborted  <= 1'b0;
            s.truth    <= '0;
            s.zero_cnt <= '0;
          end
        RUN:
          if (s.abort) begin
            state     <= IDLE;
            dwell_cnt <= '0;
            abcd      <= '0;
            s.busy    <= 1'b0;
            s.aborted <= 1'b1;
          end else if (sample) begin
            dwell_cnt            <= '0;
            s.truth[s.vec_idx]   <= s.f_in;
            s.zero_cnt           <= s.zero_cnt + 5'(!s.f_in);
            if (s.vec_idx == 4'd15) begin
              state  <= FIN;
              abcd   <= '0;
              s.busy <= 1'b0;
              s.done <= 1'b1;
            end else begin
              s.vec_idx <= s.vec_idx + 4'd1;
              abcd      <= s.vec_idx + 4'd1;
            end
          end else
            dwell_cnt <= dwell_cnt + 4'd1;
        default:
          state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sweep_ctrl.sv
// tb_sweep_ctrl: scoreboard bench for sweep_ctrl at DWELL 4, 1 and 16
module tb_sweep_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_t = 1'b0;
  logic abort_t = 1'b0;
  int   sel = 0;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  sweep_ctrl_if i4 ();
  sweep_ctrl_if i1 ();
  sweep_ctrl_if i16 ();
  sweep_ctrl #(.DWELL(4))  u4  (.clk(clk), .rst(rst), .s(i4.slave));
  sweep_ctrl #(.DWELL(1))  u1  (.clk(clk), .rst(rst), .s(i1.slave));
  sweep_ctrl #(.DWELL(16)) u16 (.clk(clk), .rst(rst), .s(i16.slave));
  assign i4.start  = start_t && sel == 0;
  assign i4.abort  = abort_t && sel == 0;
  assign i1.start  = start_t && sel == 1;
  assign i1.abort  = abort_t && sel == 1;
  assign i16.start = start_t && sel == 2;
  assign i16.abort = abort_t && sel == 2;
  assign i4.f_in   = (i4.a ~^ i4.b) | (i4.b ~^ i4.c) | (i4.c ~^ i4.d);
  assign i1.f_in   = 1'b0;
  assign i16.f_in  = 1'b1;
  logic [31:0] s4, s1, s16, o;
  logic [3:0]  o_abcd, o_vec;
  logic        o_busy, o_done, o_ab;
  logic [15:0] o_truth;
  logic [4:0]  o_zc;
  assign s4  = {i4.a, i4.b, i4.c, i4.d, i4.vec_idx, i4.busy, i4.done, i4.aborted, i4.truth, i4.zero_cnt};
  assign s1  = {i1.a, i1.b, i1.c, i1.d, i1.vec_idx, i1.busy, i1.done, i1.aborted, i1.truth, i1.zero_cnt};
  assign s16 = {i16.a, i16.b, i16.c, i16.d, i16.vec_idx, i16.busy, i16.done, i16.aborted, i16.truth, i16.zero_cnt};
  assign o = sel == 0 ? s4 : sel == 1 ? s1 : s16;
  assign {o_abcd, o_vec, o_busy, o_done, o_ab, o_truth, o_zc} = o;
  typedef struct {
    logic [15:0] truth;
    logic [4:0]  zc;
    logic        ab;
  } exp_t;
  exp_t q[$];
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      checks++;
      if (o !== 32'h0) begin
        errors++;
        $display("FAIL reset sel=%0d got %h want 00000000", i, o);
      end
    end
    sel = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_sweep(input int s, input logic [15:0] et, input logic [4:0] ez);
    int dw;
    int k;
    exp_t e;
    dw = s == 0 ? 4 : s == 1 ? 1 : 16;
    sel = s;
    @(negedge clk);
    start_t = 1'b1;
    q.push_back('{et, ez, 1'b0});
    @(negedge clk);
    start_t = 1'b0;
    k = 0;
    while (!o_done && k <= 16 * dw + 4) begin
      checks++;
      if (o_busy !== 1'b1 || o_vec !== 4'(k / dw) || o_abcd !== 4'(k / dw)) begin
        errors++;
        $display("FAIL hold dw=%0d k=%0d got busy=%b vec=%0d abcd=%0d want busy=1 vec=abcd=%0d", dw, k, o_busy, o_vec, o_abcd, k / dw);
      end
      @(negedge clk);
      k++;
    end
    checks++;
    if (k !== 16 * dw) begin
      errors++;
      $display("FAIL latency dw=%0d got %0d want %0d", dw, k, 16 * dw);
    end
    checks++;
    if (o_busy !== 1'b0 || o_abcd !== 4'd0 || o_vec !== 4'd15) begin
      errors++;
      $display("FAIL fin dw=%0d got busy=%b abcd=%0d vec=%0d want 0 0 15", dw, o_busy, o_abcd, o_vec);
    end
    e = q.pop_front();
    checks++;
    if (o_truth !== e.truth || o_zc !== e.zc || o_ab !== e.ab) begin
      errors++;
      $display("FAIL result dw=%0d got truth=%h zc=%0d ab=%b want %h %0d %b", dw, o_truth, o_zc, o_ab, e.truth, e.zc, e.ab);
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_truth !== e.truth || o_zc !== e.zc) begin
      errors++;
      $display("FAIL idle_hold dw=%0d got done=%b busy=%b truth=%h zc=%0d want 0 0 %h %0d", dw, o_done, o_busy, o_truth, o_zc, e.truth, e.zc);
    end
  endtask
  task automatic test_abort(input int at_k);
    int dn;
    exp_t e;
    sel = 0;
    @(negedge clk);
    start_t = 1'b1;
    @(negedge clk);
    start_t = 1'b0;
    repeat (at_k) @(negedge clk);
    abort_t = 1'b1;
    q.push_back('{16'h005F, 5'd1, 1'b1});
    @(negedge clk);
    abort_t = 1'b0;
    e = q.pop_front();
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_vec !== 4'd7 || o_abcd !== 4'd0) begin
      errors++;
      $display("FAIL abort_state k=%0d got busy=%b done=%b vec=%0d abcd=%0d want 0 0 7 0", at_k, o_busy, o_done, o_vec, o_abcd);
    end
    checks++;
    if (o_truth !== e.truth || o_zc !== e.zc || o_ab !== e.ab) begin
      errors++;
      $display("FAIL abort_result k=%0d got truth=%h zc=%0d ab=%b want %h %0d %b", at_k, o_truth, o_zc, o_ab, e.truth, e.zc, e.ab);
    end
    dn = 0;
    repeat (80) begin
      @(negedge clk);
      dn += int'(o_done) + int'(o_busy);
    end
    checks++;
    if (dn !== 0) begin
      errors++;
      $display("FAIL abort_quiet k=%0d got %0d busy/done cycles want 0", at_k, dn);
    end
    abort_t = 1'b1;
    @(negedge clk);
    abort_t = 1'b0;
    checks++;
    if (o_ab !== 1'b1 || o_busy !== 1'b0 || o_truth !== 16'h005F || o_zc !== 5'd1) begin
      errors++;
      $display("FAIL abort_idle got ab=%b busy=%b truth=%h zc=%0d want 1 0 005f 1", o_ab, o_busy, o_truth, o_zc);
    end
  endtask
  task automatic test_back_to_back();
    int k;
    int dn;
    exp_t e;
    sel = 0;
    @(negedge clk);
    start_t = 1'b1;
    abort_t = 1'b1;
    q.push_back('{16'hFBDF, 5'd2, 1'b0});
    @(negedge clk);
    start_t = 1'b0;
    abort_t = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || o_ab !== 1'b0 || o_vec !== 4'd0) begin
      errors++;
      $display("FAIL start_abort got busy=%b ab=%b vec=%0d want 1 0 0", o_busy, o_ab, o_vec);
    end
    for (int n = 0; n < 2; n++) begin
      k = 0;
      while (!o_done && k < 100) begin
        start_t = k == 10 || k == 40;
        @(negedge clk);
        k++;
      end
      checks++;
      if (k !== 64) begin
        errors++;
        $display("FAIL b2b_latency run=%0d got %0d want 64", n, k);
      end
      e = q.pop_front();
      checks++;
      if (o_truth !== e.truth || o_zc !== e.zc || o_ab !== e.ab) begin
        errors++;
        $display("FAIL b2b_result run=%0d got truth=%h zc=%0d ab=%b want %h %0d %b", n, o_truth, o_zc, o_ab, e.truth, e.zc, e.ab);
      end
      if (n == 0) begin
        start_t = 1'b1;
        q.push_back('{16'hFBDF, 5'd2, 1'b0});
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
          errors++;
          $display("FAIL fin_ignore got busy=%b done=%b want 0 0", o_busy, o_done);
        end
        @(negedge clk);
        start_t = 1'b0;
        checks++;
        if (o_busy !== 1'b1 || o_vec !== 4'd0 || o_done !== 1'b0) begin
          errors++;
          $display("FAIL restart got busy=%b vec=%0d done=%b want 1 0 0", o_busy, o_vec, o_done);
        end
      end
    end
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      dn += int'(o_done) + int'(o_busy);
    end
    checks++;
    if (dn !== 0) begin
      errors++;
      $display("FAIL b2b_extra got %0d busy/done cycles want 0", dn);
    end
  endtask
  task automatic test_async_reset();
    int dn;
    sel = 0;
    @(negedge clk);
    start_t = 1'b1;
    q.push_back('{16'hFBDF, 5'd2, 1'b0});
    @(negedge clk);
    start_t = 1'b0;
    repeat (36) @(negedge clk);
    checks++;
    if (o_vec !== 4'd9 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset got vec=%0d busy=%b want 9 1", o_vec, o_busy);
    end
    #2 rst = 1'b1;
    q.delete();
    #1;
    checks++;
    if (o !== 32'h0) begin
      errors++;
      $display("FAIL async_reset got %h want 00000000", o);
    end
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      dn += int'(o_done) + int'(o_busy);
    end
    checks++;
    if (dn !== 0 || o !== 32'h0) begin
      errors++;
      $display("FAIL post_reset got %0d busy/done cycles state=%h want 0 00000000", dn, o);
    end
  endtask
  initial begin
    test_reset();
    test_sweep(0, 16'hFBDF, 5'd2);
    test_abort(29);
    test_abort(31);
    test_back_to_back();
    test_async_reset();
    test_sweep(1, 16'h0000, 5'd16);
    test_sweep(2, 16'hFFFF, 5'd0);
    checks++;
    if (q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 Parameter: DWELL, default 4, clock cycles each input vector is held before sampling; legal range 1..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a full 16-vector sweep; sampled only in IDLE.
REQ-005 abort  input  1  terminate a running sweep.
REQ-006 f_in  input  1  result F returned by the 4-input check function under test.
REQ-007 a, b, c, d  output  1 each  registered stimulus to the function; {a,b,c,d} = current vector, a = MSB.
REQ-008 vec_idx  output  4  index of the vector currently driven.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse on sweep completion.
REQ-011 aborted  output  1  level; set by abort, cleared by next accepted start.
REQ-012 truth  output  16  captured results; bit i = f_in sampled for vector i.
REQ-013 zero_cnt  output  5  number of vectors whose sampled f_in was 0 (0..16).

Function
REQ-014 The FSM SHALL have states IDLE, RUN, FIN; all outputs SHALL be registered.
REQ-015 In IDLE with start=1: next state RUN; vec_idx<=0, dwell counter<=0, truth<=0, zero_cnt<=0, aborted<=0, busy<=1.
REQ-016 In RUN, {a,b,c,d} SHALL equal vec_idx; in IDLE and FIN they SHALL be 0.
REQ-017 In RUN, the dwell counter SHALL increment each cycle; in the cycle where it equals DWELL-1, truth[vec_idx]<=f_in, zero_cnt increments iff f_in=0, and the dwell counter returns to 0.
REQ-018 At that sample cycle: if vec_idx<15, vec_idx increments (no wrap); if vec_idx=15, next state FIN and vec_idx holds 15.
REQ-019 FIN SHALL last exactly one cycle with done=1, busy=0, then go to IDLE; done SHALL be 0 in all other cycles.
REQ-020 Latency: with start accepted at edge E0, done SHALL be high in the cycle following edge E0+16*DWELL; each vector SHALL be driven for exactly DWELL cycles.
REQ-021 start SHALL be ignored in RUN and FIN.
REQ-022 abort in RUN SHALL move to IDLE next edge, set aborted=1, busy=0, no done pulse; abort has priority over a same-cycle sample (that sample is discarded).
REQ-023 abort in IDLE or FIN SHALL have no effect.
REQ-024 truth, zero_cnt and vec_idx SHALL hold their last values in IDLE until the next accepted start (partial results retained after abort).
REQ-025 start and abort both high in IDLE: start accepted, abort ignored.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, a=b=c=d=0, vec_idx=0, busy=0, done=0, aborted=0, truth=0, zero_cnt=0, dwell counter=0, regardless of clk.
REQ-027 rst asserted mid-sweep SHALL discard the sweep with no done pulse; after release, no sweep begins without a new start.

Verification
REQ-028 DWELL=4, f_in driven by the team's check function F=(A^~B)|(B^~C)|(C^~D), pulse start -> 64 RUN cycles, done pulse in the next cycle, truth=16'hFBDF, zero_cnt=2, aborted=0.
REQ-029 DWELL=4, abort while vec_idx=7 in its 2nd dwell cycle -> IDLE next edge, aborted=1, no done, truth[6:0] = 7'h5F, truth[15:7]=0, zero_cnt=1.
REQ-030 Start pulses repeated during RUN and during FIN -> no restart; exactly one done pulse per accepted start; busy low for 1 cycle (FIN) before a new start can be accepted.
REQ-031 Async rst asserted between clock edges at vec_idx=9 -> all outputs at reset values before the next edge; no done afterward without new start.
REQ-032 DWELL=1, f_in tied 0 -> done in cycle after edge E0+16, truth=16'h0000, zero_cnt=16 (5'b10000, no overflow).
REQ-033 DWELL=16, f_in tied 1 -> each vector held exactly 16 cycles (checked per vector), truth=16'hFFFF, zero_cnt=0.
